// File: rtl/sar_pkg.sv
// Shared state encoding and default sizing for the multi-channel SAR controller.
package sar_pkg;

  localparam int SAR_STW       = 2;
  localparam int SAR_NBITS_DEF = 8;
  localparam int SAR_NSAMP_DEF = 2;

  typedef enum logic [SAR_STW-1:0] {
    IDLE = 2'd0,
    SAMP = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } sar_state_t;

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation search engine: one NBITS binary search per start pulse.
// Latency: NBITS cycles from the start edge; fin flags the last trial cycle.
// Backpressure: none, the controller owns pacing; trial is zero whenever idle.
module sar_bit_engine
  import sar_pkg::*;
#(
  parameter int NBITS = SAR_NBITS_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             cmp,
  output logic [NBITS-1:0] trial,
  output logic [NBITS-1:0] code_nxt,
  output logic             fin
);

  logic [NBITS-1:0] code;
  logic [NBITS-1:0] bitm;
  logic             active;

  // code_nxt is the code as it will stand after this cycle's decision.
  assign code_nxt = code | (cmp ? bitm : '0);
  assign fin      = active & bitm[0];
  assign trial    = active ? (code | bitm) : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      code   <= '0;
      bitm   <= '0;
      active <= 1'b0;
    end else if (start) begin
      code   <= '0;
      bitm   <= {1'b1, {(NBITS-1){1'b0}}};
      active <= 1'b1;
    end else if (active) begin
      code <= code_nxt;
      bitm <= bitm >> 1;
      if (bitm[0]) active <= 1'b0;
    end
  end

endmodule

// File: rtl/sar_logic_mc.sv
// Multi-channel SAR scan controller; SAR_AVG_EN averages 2^AVG_LOG2 passes per channel.
// Latency: NSAMP+NBITS cycles from GO sample to VALID; channel period NSAMP+NBITS+1.
// Backpressure: none; VALID is a one-cycle pulse and DATA holds until the next one.
module sar_logic_mc
  import sar_pkg::*;
#(
  parameter int NBITS    = SAR_NBITS_DEF,
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int NSAMP    = SAR_NSAMP_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             go,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp,
  output logic             sample,
  output logic [CHW-1:0]   ch_sel,
  output logic [NBITS-1:0] resultp,
  output logic [NBITS-1:0] resultn,
  output logic [NBITS-1:0] data,
  output logic [CHW-1:0]   data_ch,
  output logic             valid,
  output logic             busy
);

  localparam int SCW = (NSAMP > 1) ? $clog2(NSAMP) : 1;

  if (NBITS < 2 || NCH < 1 || NSAMP < 1 || AVG_LOG2 < 0 || CHW < 1) begin : g_bad_param
    $error("sar_logic_mc: illegal parameter set");
  end

  sar_state_t       state;
  logic [SCW-1:0]   scnt;
  logic [NCH-1:0]   mask_q;
  logic             eng_start;
  logic             eng_fin;
  logic [NBITS-1:0] eng_code;
  logic             nxt_hit;
  logic [CHW-1:0]   nxt_ch;
  logic [CHW-1:0]   first_ch;

`ifdef SAR_AVG_EN
  localparam int ACCW = NBITS + AVG_LOG2;
  localparam int PW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PW-1:0] PASS_LAST = PW'((1 << AVG_LOG2) - 1);
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_nxt;
  logic [PW-1:0]   pass;
  assign acc_nxt = acc + ACCW'(eng_code);
`endif

  // The search starts on the edge that ends the last sample cycle.
  assign eng_start = (state == SAMP) && (scnt == SCW'(NSAMP - 1));
  assign resultn   = ~resultp;

  sar_bit_engine #(.NBITS(NBITS)) u_eng (
    .clk      (clk),
    .rstn     (rstn),
    .start    (eng_start),
    .cmp      (cmp),
    .trial    (resultp),
    .code_nxt (eng_code),
    .fin      (eng_fin)
  );

  // Next higher enabled channel of the latched mask, and lowest enabled one of the live mask.
  always_comb begin
    nxt_hit  = 1'b0;
    nxt_ch   = '0;
    first_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mask_q[i] && (i > int'(ch_sel)) && !nxt_hit) begin
        nxt_hit = 1'b1;
        nxt_ch  = CHW'(i);
      end
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = CHW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      scnt    <= '0;
      mask_q  <= '0;
      ch_sel  <= '0;
      sample  <= 1'b0;
      data    <= '0;
      data_ch <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
`ifdef SAR_AVG_EN
      acc     <= '0;
      pass    <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (go && (ch_mask != '0)) begin
            mask_q <= ch_mask;
            ch_sel <= first_ch;
            state  <= SAMP;
            sample <= 1'b1;
            scnt   <= '0;
            busy   <= 1'b1;
          end
        end
        SAMP: begin
          if (scnt == SCW'(NSAMP - 1)) begin
            state  <= CONV;
            sample <= 1'b0;
          end else begin
            scnt <= scnt + SCW'(1);
          end
        end
        CONV: begin
          if (eng_fin) begin
`ifdef SAR_AVG_EN
            if (pass == PASS_LAST) begin
              state   <= DONE;
              data    <= acc_nxt[ACCW-1 -: NBITS];
              data_ch <= ch_sel;
              valid   <= 1'b1;
              acc     <= '0;
              pass    <= '0;
            end else begin
              acc    <= acc_nxt;
              pass   <= pass + PW'(1);
              state  <= SAMP;
              sample <= 1'b1;
              scnt   <= '0;
            end
`else
            state   <= DONE;
            data    <= eng_code;
            data_ch <= ch_sel;
            valid   <= 1'b1;
`endif
          end
        end
        DONE: begin
          if (nxt_hit) begin
            ch_sel <= nxt_ch;
            state  <= SAMP;
            sample <= 1'b1;
            scnt   <= '0;
          end else if (cont && (ch_mask != '0)) begin
            mask_q <= ch_mask;
            ch_sel <= first_ch;
            state  <= SAMP;
            sample <= 1'b1;
            scnt   <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_logic_mc.sv
// Scoreboard bench for sar_logic_mc: analog inputs modelled as per-channel codes.
module tb_sar_logic_mc;

  localparam int NBITS = 8;
  localparam int NCH   = 4;
  localparam int NSAMP = 2;
`ifdef SAR_AVG_EN
  localparam int PASSES = 4;
`else
  localparam int PASSES = 1;
`endif
  localparam int PER = PASSES * (NSAMP + NBITS) + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             go = 1'b0;
  logic             cont = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic             cmp;
  logic             sample;
  logic [1:0]       ch_sel;
  logic [NBITS-1:0] resultp;
  logic [NBITS-1:0] resultn;
  logic [NBITS-1:0] data;
  logic [1:0]       data_ch;
  logic             valid;
  logic             busy;

  // cmp_mode: 0 comparator stuck low, 1 stuck high, 2 ideal comparator against vin[channel]
  int         cmp_mode = 0;
  logic [7:0] vin [NCH];

  assign cmp = (cmp_mode == 0) ? 1'b0 :
               (cmp_mode == 1) ? 1'b1 : (resultp <= vin[ch_sel]);

  sar_logic_mc dut (
    .clk     (clk),
    .rstn    (rstn),
    .go      (go),
    .cont    (cont),
    .ch_mask (ch_mask),
    .cmp     (cmp),
    .sample  (sample),
    .ch_sel  (ch_sel),
    .resultp (resultp),
    .resultn (resultn),
    .data    (data),
    .data_ch (data_ch),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
    int         t;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int passes = 0;
  int rn_bad = 0;
  int samp_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // An ideal binary search lands exactly on the input code; averaging identical passes keeps it.
  function automatic logic [7:0] expv(input int ch);
    if (cmp_mode == 0) return 8'h00;
    if (cmp_mode == 1) return 8'hFF;
    return vin[ch];
  endfunction

  always @(negedge clk) begin
    if (resultn !== ~resultp) rn_bad++;
    if (sample) samp_run++;
    else if (samp_run != 0) begin
      chk("sample_len", samp_run, NSAMP);
      samp_run = 0;
    end
    if (valid) begin
      if (sbq.size() == 0) chk("valid_unexpected", valid, 1'b0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("data", data, e.d);
        chk("data_ch", data_ch, e.ch);
        chk("valid_time", cyc, e.t);
      end
    end else if (sbq.size() != 0 && cyc > sbq[0].t) begin
      exp_t e;
      e = sbq.pop_front();
      chk("valid_missing", cyc, e.t);
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Queue one scan: channels in ascending order, back to back at PER spacing after t.
  task automatic push_scan(input logic [3:0] m, inout int t);
    exp_t e;
    for (int ch = 0; ch < NCH; ch++) begin
      if (m[ch]) begin
        t    = t + PER;
        e.ch = 2'(ch);
        e.d  = expv(ch);
        e.t  = t;
        sbq.push_back(e);
      end
    end
  endtask

  // GO is raised at negedge of cycle t0; first VALID appears PER cycles later.
  task automatic run_scans(input logic [3:0] m0, input int nscans, input bit rnd_next);
    int t;
    int tf;
    logic [3:0] m;
    logic [3:0] nm;
    bit last;
    @(negedge clk);
    go = 1'b1;
    ch_mask = m0;
    cont = 1'b0;
    t = cyc;
    m = m0;
    @(negedge clk);
    go = 1'b0;
    for (int s = 0; s < nscans; s++) begin
      tf = t + PER;
      push_scan(m, t);
      nm = rnd_next ? 4'($urandom_range(0, 15)) : m;
      last = (s == nscans - 1) || (nm == 4'h0);
      wait_cyc(tf);
      if (s == nscans - 1) begin
        cont = 1'b0;
        ch_mask = 4'($urandom_range(0, 15));
      end else begin
        cont = 1'b1;
        ch_mask = nm;
      end
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      m = nm;
      if (last) break;
    end
    wait_cyc(t + 1);
    chk("busy_after_scan", busy, 1'b0);
    chk("sbq_drained", sbq.size(), 0);
  endtask

  initial begin
    int t;
    rstn = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_sample", sample, 1'b0);
    chk("rst_ch_sel", ch_sel, 2'd0);
    chk("rst_resultp", resultp, 8'h00);
    chk("rst_resultn", resultn, 8'hFF);
    chk("rst_data", data, 8'h00);
    chk("rst_data_ch", data_ch, 2'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;

    cmp_mode = 1;
    run_scans(4'b0001, 1, 1'b0);
    cmp_mode = 0;
    run_scans(4'b1010, 1, 1'b0);

    cmp_mode = 2;
    foreach (vin[i]) vin[i] = 8'hA5;
    run_scans(4'b0001, 1, 1'b0);
    run_scans(4'b1111, 1, 1'b0);

    foreach (vin[i]) vin[i] = 8'($urandom);
    run_scans(4'b1001, 3, 1'b0);

    for (int it = 0; it < 6; it++) begin
      foreach (vin[i]) vin[i] = 8'($urandom);
      run_scans(4'($urandom_range(1, 15)), $urandom_range(1, 3), 1'b1);
    end

    @(negedge clk);
    ch_mask = 4'b0000;
    go = 1'b1;
    repeat (3) @(negedge clk);
    go = 1'b0;
    chk("mask0_busy", busy, 1'b0);
    chk("mask0_sample", sample, 1'b0);

    cmp_mode = 1;
    run_scans(4'b0100, 1, 1'b0);
    @(negedge clk);
    ch_mask = 4'b1000;
    go = 1'b1;
    t = cyc;
    @(negedge clk);
    go = 1'b0;
    wait_cyc(t + 6);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_sample", sample, 1'b0);
    chk("midrst_ch_sel", ch_sel, 2'd0);
    chk("midrst_resultp", resultp, 8'h00);
    chk("midrst_resultn", resultn, 8'hFF);
    chk("midrst_data", data, 8'h00);
    chk("midrst_data_ch", data_ch, 2'd0);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rstn = 1'b1;
    repeat (PER + 5) @(negedge clk);
    chk("midrst_idle", busy, 1'b0);

    cmp_mode = 2;
    foreach (vin[i]) vin[i] = 8'h40;
    run_scans(4'b0001, 1, 1'b0);

    chk("resultn_inv", rn_bad, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
